// File: rtl/slot_txrx_sched_pkg.sv
// rtl/slot_txrx_sched_pkg.sv - shared state encoding, timing defaults and slot helpers
package slot_txrx_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_TX_AC   = 3'd1,
      ST_TX_BODY = 3'd2,
      ST_RX_WIN  = 3'd3,
      ST_RX_BODY = 3'd4,
      ST_HOLD    = 3'd5
   } sched_state_e;

   localparam int ACLEN_DEF  = 72;
   localparam int RXWIN_DEF  = 20;
   localparam int SLOTUS_DEF = 625;

   localparam logic [2:0] SLOTS_1 = 3'd1;
   localparam logic [2:0] SLOTS_3 = 3'd3;
   localparam logic [2:0] SLOTS_5 = 3'd5;

   localparam int AC_W = 7;
   localparam int WD_W = 12;

   // Packets span an odd number of slots; 0 means single-slot, odd-less values round up.
   function automatic logic [2:0] norm_slots(input logic [2:0] s);
      case (s)
         3'd0, SLOTS_1: return SLOTS_1;
         3'd2, SLOTS_3: return SLOTS_3;
         default:       return SLOTS_5;
      endcase
   endfunction

   function automatic sched_state_e slot_decide(input logic master, input logic odd,
                                                input logic req, input logic grant);
      sched_state_e d;
      d = ST_IDLE;
      if (master) begin
         if (odd)      d = ST_RX_WIN;
         else if (req) d = ST_TX_AC;
      end else begin
         if (!odd)              d = ST_RX_WIN;
         else if (req && grant) d = ST_TX_AC;
      end
      return d;
   endfunction

endpackage

// File: rtl/slot_txrx_sched_if.sv
// rtl/slot_txrx_sched_if.sv - slot scheduler control and status bundle
interface slot_txrx_sched_if;
   logic       p_1us;
   logic       s_tslot_p;
   logic       slot_odd;
   logic       conns_en;
   logic       is_master;
   logic       tx_req;
   logic [2:0] occupy_slots;
   logic       tx_done_p;
   logic       sync_found_p;
   logic       rx_packet_end_p;
   logic       lt_addressed;
   logic       pk_encode;
   logic       tx_packet_st_p;
   logic       rx_window;
   logic       rx_timeout_p;
   logic       tx_abort_p;
   logic [2:0] sched_state;

   modport master (
      output p_1us, s_tslot_p, slot_odd, conns_en, is_master, tx_req, occupy_slots,
             tx_done_p, sync_found_p, rx_packet_end_p, lt_addressed,
      input  pk_encode, tx_packet_st_p, rx_window, rx_timeout_p, tx_abort_p, sched_state
   );

   modport slave (
      input  p_1us, s_tslot_p, slot_odd, conns_en, is_master, tx_req, occupy_slots,
             tx_done_p, sync_found_p, rx_packet_end_p, lt_addressed,
      output pk_encode, tx_packet_st_p, rx_window, rx_timeout_p, tx_abort_p, sched_state
   );
endinterface

// File: rtl/slot_us_timer.sv
// rtl/slot_us_timer.sv - p_1us counter with clear, saturation and limit-reach strobe
module slot_us_timer #(
   parameter int WIDTH = 7
) (
   input  logic             clk_6M,
   input  logic             rst,
   input  logic             clr,
   input  logic             tick,
   input  logic [WIDTH-1:0] limit,
   output logic             hit
);
   logic [WIDTH-1:0] count;
   logic             at_max;

   assign at_max = (count == {WIDTH{1'b1}});

   always_ff @(posedge clk_6M or posedge rst) begin
      if (rst)                  count <= '0;
      else if (clr)             count <= '0;
      else if (tick && !at_max) count <= count + WIDTH'(1);
   end

   // Flags the tick that carries the count onto limit, so the owner reacts in that same cycle.
   assign hit = tick && !at_max && ((count + WIDTH'(1)) == limit);
endmodule

// File: rtl/slot_txrx_sched.sv
// rtl/slot_txrx_sched.sv - per-slot TX/RX sequencer with occupancy tracking and watchdogs
module slot_txrx_sched
   import slot_txrx_sched_pkg::*;
#(
   parameter int ACLEN  = ACLEN_DEF,
   parameter int RXWIN  = RXWIN_DEF,
   parameter int SLOTUS = SLOTUS_DEF
) (
   input logic              clk_6M,
   input logic              rst,
   slot_txrx_sched_if.slave io
);
   sched_state_e    state, state_nxt;
   logic            slave_tx_grant, grant_nxt;
   logic [2:0]      slots_q;
   logic            entering;
   logic            ac_hit, wd_hit;
   logic [AC_W-1:0] ac_limit;
   logic [WD_W-1:0] wd_limit, tx_wd_limit;
   logic            tx_packet_st, rx_timeout, tx_abort;

   assign entering    = (state_nxt != state);
   assign ac_limit    = (state == ST_RX_WIN) ? AC_W'(RXWIN) : AC_W'(ACLEN);
   assign tx_wd_limit = WD_W'(int'(slots_q) * SLOTUS - 1);
   assign wd_limit    = (state == ST_RX_BODY) ? WD_W'(int'(SLOTS_5) * SLOTUS) : tx_wd_limit;

   slot_us_timer #(.WIDTH(AC_W)) u_ac_timer (
      .clk_6M (clk_6M),
      .rst    (rst),
      .clr    (entering),
      .tick   (io.p_1us),
      .limit  (ac_limit),
      .hit    (ac_hit)
   );

   // The TX watchdog spans access code and body, so entering TX_BODY does not restart it.
   slot_us_timer #(.WIDTH(WD_W)) u_wd_timer (
      .clk_6M (clk_6M),
      .rst    (rst),
      .clr    (entering && (state_nxt != ST_TX_BODY)),
      .tick   (io.p_1us),
      .limit  (wd_limit),
      .hit    (wd_hit)
   );

   always_ff @(posedge clk_6M or posedge rst) begin
      if (rst) begin
         state          <= ST_IDLE;
         slave_tx_grant <= 1'b0;
         slots_q        <= SLOTS_1;
      end else begin
         state          <= state_nxt;
         slave_tx_grant <= grant_nxt;
         if (state_nxt == ST_TX_AC && state != ST_TX_AC)
            slots_q <= norm_slots(io.occupy_slots);
      end
   end

   always_comb begin
      state_nxt    = state;
      grant_nxt    = slave_tx_grant;
      tx_packet_st = 1'b0;
      rx_timeout   = 1'b0;
      tx_abort     = 1'b0;
      if (!io.conns_en) begin
         state_nxt = ST_IDLE;
         grant_nxt = 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_HOLD: begin
               if (io.s_tslot_p)
                  state_nxt = slot_decide(io.is_master, io.slot_odd, io.tx_req, slave_tx_grant);
            end
            ST_TX_AC: begin
               if (ac_hit) begin
                  tx_packet_st = 1'b1;
                  state_nxt    = ST_TX_BODY;
               end
            end
            ST_TX_BODY: begin
               if (io.tx_done_p) begin
                  state_nxt = ST_IDLE;
               end else if (wd_hit) begin
                  tx_abort  = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end
            ST_RX_WIN: begin
               if (io.sync_found_p) begin
                  state_nxt = ST_RX_BODY;
                  grant_nxt = 1'b0;
               end else if (ac_hit) begin
                  rx_timeout = 1'b1;
                  state_nxt  = ST_IDLE;
                  grant_nxt  = 1'b0;
               end
            end
            ST_RX_BODY: begin
               if (io.rx_packet_end_p) begin
                  state_nxt = ST_HOLD;
                  grant_nxt = io.lt_addressed & ~io.is_master;
               end else if (wd_hit) begin
                  state_nxt = ST_IDLE;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   assign io.pk_encode      = (state == ST_TX_AC) || (state == ST_TX_BODY);
   assign io.rx_window      = (state == ST_RX_WIN);
   assign io.sched_state    = state;
   assign io.tx_packet_st_p = tx_packet_st;
   assign io.rx_timeout_p   = rx_timeout;
   assign io.tx_abort_p     = tx_abort;
endmodule
